mem_port_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between two requesters: the instruction-fetch requester (if_*) and the data-memory requester (dm_*, load/store from the MEM stage).
- Sits between the pipeline stages and the memory macro.
- Grants one access at a time, sequences the fixed-latency memory, and returns read data with a one-cycle valid pulse.
- Data port has priority over fetch; an anti-starvation counter guarantees fetch progress. Supports fetch cancellation on taken branch and halt.

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between instruction fetch
// and the data port; data wins unless fetch has been starved STARVE_MAX times.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM
    } owner_t;

    localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      r_state;
    owner_t      r_owner;
    logic [2:0]  r_lat_cnt;
    logic [3:0]  r_starve_cnt;
    logic        r_cancel;
    logic        r_we;

    logic        w_any_req;
    logic        w_dm_wins;
    logic        w_lat_done;
    logic        w_cancelled;

    always_comb begin
        w_any_req   = if_req | dm_req;
        w_dm_wins   = dm_req && !(if_req && (r_starve_cnt == STARVE_LIM));
        w_lat_done  = (r_lat_cnt == '0);
        // a flush arriving on the completion edge still suppresses the response
        w_cancelled = r_cancel | ((r_owner == OWN_IF) && if_flush);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_NONE;
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
            r_cancel     <= 1'b0;
            r_we         <= 1'b0;
            if_gnt       <= 1'b0;
            if_rvalid    <= 1'b0;
            if_rdata     <= '0;
            dm_gnt       <= 1'b0;
            dm_rvalid    <= 1'b0;
            dm_rdata     <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!halt && w_any_req) begin
                        r_state   <= S_ACCESS;
                        r_lat_cnt <= LAT_LOAD;
                        r_cancel  <= 1'b0;
                        mem_en    <= 1'b1;
                        busy      <= 1'b1;
                        if (w_dm_wins) begin
                            r_owner   <= OWN_DM;
                            r_we      <= dm_we;
                            dm_gnt    <= 1'b1;
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            if (if_req && (r_starve_cnt != STARVE_LIM)) begin
                                r_starve_cnt <= r_starve_cnt + 4'd1;
                            end
                        end else begin
                            r_owner      <= OWN_IF;
                            r_we         <= 1'b0;
                            if_gnt       <= 1'b1;
                            mem_addr     <= if_addr;
                            mem_wdata    <= '0;
                            r_starve_cnt <= '0;
                        end
                    end
                end

                S_ACCESS: begin
                    if ((r_owner == OWN_IF) && if_flush) begin
                        r_cancel <= 1'b1;
                    end
                    if (w_lat_done) begin
                        r_state  <= S_IDLE;
                        r_owner  <= OWN_NONE;
                        r_cancel <= 1'b0;
                        busy     <= 1'b0;
                        if (r_owner == OWN_DM) begin
                            dm_rvalid <= 1'b1;
                            if (!r_we) begin
                                dm_rdata <= mem_rdata;
                            end
                        end else if (r_owner == OWN_IF && !w_cancelled) begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 3'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a timestamp-based transaction model checked
// every cycle, plus literal expectations for each scenario.
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_flush = 1'b0;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] mem_rdata = 32'hBAD0_BAD0;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .halt     (halt),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_gnt   (dm_gnt),
        .dm_rvalid(dm_rvalid),
        .dm_rdata (dm_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void chk_str(input string name, input string act, input string exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %s expected %s (cycle %0d)", name, act, exp, cyc);
    endfunction

    // memory macro (bench side) and the model's own view of its contents
    logic [31:0] bmem [256];
    logic [31:0] mref [256];
    int          age = 100;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dreq_t;
    dreq_t       dq[$];
    logic [31:0] iq[$];

    function automatic void drive_reqs();
        dm_req = (dq.size() != 0);
        if_req = (iq.size() != 0);
        if (dm_req) begin
            dm_we = dq[0].we; dm_addr = dq[0].addr; dm_wdata = dq[0].wdata;
        end else begin
            dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        end
        if_addr = if_req ? iq[0] : '0;
    endfunction

    // transaction model: an access granted at cycle c completes at c + MEM_LAT
    logic        m_in_acc, m_own_dm, m_we, m_cancel;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
    int          m_done, m_starve;
    logic        e_if_gnt, e_dm_gnt, e_mem_en, e_mem_we, e_if_rv, e_dm_rv, e_busy;

    function automatic void model_reset();
        m_in_acc = 0; m_own_dm = 0; m_we = 0; m_cancel = 0;
        m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
        m_done = 0; m_starve = 0;
        e_if_gnt = 0; e_dm_gnt = 0; e_mem_en = 0; e_mem_we = 0;
        e_if_rv = 0; e_dm_rv = 0; e_busy = 0;
    endfunction

    function automatic void model_step();
        logic dm_wins;
        e_if_gnt = 0; e_dm_gnt = 0; e_mem_en = 0; e_mem_we = 0; e_if_rv = 0; e_dm_rv = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_in_acc) begin
            if (!m_own_dm && if_flush) m_cancel = 1;
            if (cyc == m_done) begin
                if (m_own_dm) begin
                    e_dm_rv = 1;
                    if (!m_we) m_dm_rdata = mref[m_addr[9:2]];
                end else if (!m_cancel) begin
                    e_if_rv = 1;
                    m_if_rdata = mref[m_addr[9:2]];
                end
                m_in_acc = 0;
                m_cancel = 0;
            end
        end else if (!halt && (if_req || dm_req)) begin
            dm_wins  = dm_req && !(if_req && m_starve == STARVE_MAX);
            m_in_acc = 1;
            m_done   = cyc + MEM_LAT;
            m_cancel = 0;
            e_mem_en = 1;
            if (dm_wins) begin
                e_dm_gnt = 1; m_own_dm = 1;
                m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata; e_mem_we = dm_we;
                if (dm_we) mref[dm_addr[9:2]] = dm_wdata;
                if (if_req) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
            end else begin
                e_if_gnt = 1; m_own_dm = 0;
                m_addr = if_addr; m_we = 0;
                m_starve = 0;
            end
        end
        e_busy = m_in_acc;
    endfunction

    // per-scenario event logs
    string ord;
    int    n_busy, n_we, n_dm_rv, n_if_rv, n_if_gnt;
    int    dm_gnt_cyc, dm_rv_cyc, last_gnt, min_gap;
    logic [31:0] we_data;

    function automatic void clear_logs();
        ord = ""; n_busy = 0; n_we = 0; n_dm_rv = 0; n_if_rv = 0; n_if_gnt = 0;
        dm_gnt_cyc = -1; dm_rv_cyc = -1; last_gnt = -1; min_gap = 1000; we_data = '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        chk("if_gnt",    32'(if_gnt),    32'(e_if_gnt));
        chk("dm_gnt",    32'(dm_gnt),    32'(e_dm_gnt));
        chk("mem_en",    32'(mem_en),    32'(e_mem_en));
        chk("mem_we",    32'(mem_we),    32'(e_mem_we));
        chk("busy",      32'(busy),      32'(e_busy));
        chk("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
        chk("dm_rvalid", 32'(dm_rvalid), 32'(e_dm_rv));
        chk("if_rdata",  if_rdata,  m_if_rdata);
        chk("dm_rdata",  dm_rdata,  m_dm_rdata);
        chk("mem_addr",  mem_addr,  m_addr);
        if (e_mem_we) chk("mem_wdata", mem_wdata, m_wdata);

        if (dm_gnt || if_gnt) begin
            ord = {ord, dm_gnt ? "D" : "I"};
            if (last_gnt >= 0 && cyc - last_gnt < min_gap) min_gap = cyc - last_gnt;
            last_gnt = cyc;
        end
        if (dm_gnt) dm_gnt_cyc = cyc;
        if (if_gnt) n_if_gnt++;
        if (dm_rvalid) begin n_dm_rv++; dm_rv_cyc = cyc; end
        if (if_rvalid) n_if_rv++;
        if (busy) n_busy++;
        if (mem_we) begin n_we++; we_data = mem_wdata; end

        if (mem_en && mem_we) bmem[mem_addr[9:2]] = mem_wdata;
        if (mem_en) age = 0;
        else if (age < 100) age++;
        mem_rdata = (age == MEM_LAT - 1) ? bmem[mem_addr[9:2]] : 32'hBAD0_BAD0;

        @(negedge clk);
        if (dm_gnt && dq.size() != 0) void'(dq.pop_front());
        if (if_gnt && iq.size() != 0) void'(iq.pop_front());
        drive_reqs();
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((dq.size() != 0 || iq.size() != 0 || busy || if_req || dm_req) && g < 80) begin
            tick();
            g++;
        end
        if (g >= 80) chk("idle_timeout", 32'(g), 32'd0);
        tick();
    endtask

    task automatic wait_if_gnt();
        int g = 0;
        while (!if_gnt && g < 40) begin
            tick();
            g++;
        end
        if (g >= 40) chk("if_gnt_timeout", 32'(g), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        for (int i = 0; i < 256; i++) begin
            bmem[i] = 32'hC0DE_0000 | 32'(i);
        end
        bmem[8'h10] = 32'hDEAD_BEEF;
        for (int i = 0; i < 256; i++) mref[i] = bmem[i];
        model_reset();
        clear_logs();
        drive_reqs();

        repeat (3) tick();
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_rdata",  dm_rdata,    32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // dm load from 0x40
        clear_logs();
        k = cyc;
        dq.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
        drive_reqs();
        wait_idle();
        chk("load_gnt_latency", 32'(dm_gnt_cyc - k), 32'd1);
        chk("load_rv_latency",  32'(dm_rv_cyc - dm_gnt_cyc), 32'd2);
        chk("load_data",        dm_rdata, 32'hDEAD_BEEF);
        chk("load_busy_cycles", 32'(n_busy), 32'd2);
        chk("load_rv_count",    32'(n_dm_rv), 32'd1);

        // store 0x12345678 to 0x10
        clear_logs();
        dq.push_back('{we: 1'b1, addr: 32'h10, wdata: 32'h1234_5678});
        drive_reqs();
        wait_idle();
        chk("store_we_cycles", 32'(n_we), 32'd1);
        chk("store_wdata",     we_data, 32'h1234_5678);
        chk("store_ack",       32'(n_dm_rv), 32'd1);
        chk("store_rdata_hold", dm_rdata, 32'hDEAD_BEEF);

        // both ports contending: fetch forced through after STARVE_MAX data grants
        clear_logs();
        for (int i = 0; i < 6; i++) dq.push_back('{we: 1'b0, addr: 32'h80 + 32'(4 * i), wdata: 32'h0});
        for (int i = 0; i < 2; i++) iq.push_back(32'h100 + 32'(4 * i));
        drive_reqs();
        wait_idle();
        chk_str("starve_order", ord, "DDDDIDDI");
        chk("starve_min_gap", 32'(min_gap), 32'd3);

        // halt blocks the grant, release grants on the next edge
        clear_logs();
        halt = 1'b1;
        iq.push_back(32'h30);
        drive_reqs();
        repeat (10) tick();
        chk("halt_no_gnt", 32'(n_if_gnt), 32'd0);
        halt = 1'b0;
        tick();
        chk("halt_release_gnt", 32'(if_gnt), 32'd1);
        wait_idle();
        chk("halt_fetch_data", if_rdata, 32'hC0DE_000C);

        // reset during an access
        clear_logs();
        iq.push_back(32'h28);
        drive_reqs();
        wait_if_gnt();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_mem_en", 32'(mem_en), 32'd0);
        chk("arst_busy",   32'(busy),   32'd0);
        chk("arst_if_rdata", if_rdata, 32'd0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        model_reset();
        dq.delete();
        iq.delete();
        drive_reqs();
        repeat (3) tick();
        chk("arst_no_rvalid", 32'(n_if_rv), 32'd0);
        rst_n = 1'b1;
        tick();
        iq.push_back(32'h24);
        drive_reqs();
        wait_idle();
        chk("arst_fresh_rv",   32'(n_if_rv), 32'd1);
        chk("arst_fresh_data", if_rdata, 32'hC0DE_0009);

        // flush a fetch in flight, then a data load proceeds
        clear_logs();
        iq.push_back(32'h20);
        drive_reqs();
        wait_if_gnt();
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        dq.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0});
        drive_reqs();
        wait_idle();
        chk("flush_no_rvalid",  32'(n_if_rv), 32'd0);
        chk("flush_rdata_hold", if_rdata, 32'hC0DE_0009);
        chk("flush_next_load_rv", 32'(n_dm_rv), 32'd1);
        chk("flush_next_load_data", dm_rdata, 32'h1234_5678);

        // flush while idle does nothing to the next fetch
        clear_logs();
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        iq.push_back(32'h34);
        drive_reqs();
        wait_idle();
        chk("idle_flush_rv",   32'(n_if_rv), 32'd1);
        chk("idle_flush_data", if_rdata, 32'hC0DE_000D);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
